counter_cmd_sequencer: RTL and testbench

Initiator side of the counter control interface. Accepts commands (load, count up, count down, hold) through a valid/ready port and queues them in a small FIFO. Executes each command by driving en_ctrl/set_ctrl/up_ctrl/counter value to the downstream up/down counter for a programmed number of cycles. Also watches the counter's overflow flag and reports it sticky.

---
 rtl/counter_cmd_sequencer.sv | 248 ++++++++++++++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// counter_cmd_sequencer
//
// Initiator side of the counter control interface. Commands (HOLD, LOAD,
// COUNT_UP, COUNT_DOWN) arrive on a valid/ready port and are queued in a small
// FIFO. The executor pops one command at a time and drives the downstream
// up/down counter controls for the programmed number of cycles. The counter's
// overflow flag is watched while counting and reported as a sticky bit.
//
// Ports:
//   clk_in             clock, all state updates on the rising edge
//   rst_in             asynchronous active-low reset
//   cmd_valid_in       command present on cmd_op_in / cmd_data_in
//   cmd_ready_out      FIFO not full (combinational from occupancy)
//   cmd_op_in          00 HOLD, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN
//   cmd_data_in        LOAD: value to load; others: cycle count N
//   en_ctrl_out        counter enable (registered)
//   set_ctrl_out       counter load strobe (registered)
//   up_ctrl_out        count direction, 1 = up (registered)
//   counter_value_out  load value for the counter (registered)
//   ovf_in             overflow flag from the counter
//   ovf_seen_out       sticky: ovf_in seen high while counting (registered)
//   done_out           one-cycle pulse in the final cycle of each command
//   busy_out           executor active or commands queued (registered)
// -----------------------------------------------------------------------------
module counter_cmd_sequencer #(
  parameter int width = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_out,
  input  logic [1:0]       cmd_op_in,
  input  logic [width-1:0] cmd_data_in,
  output logic             en_ctrl_out,
  output logic             set_ctrl_out,
  output logic             up_ctrl_out,
  output logic [width-1:0] counter_value_out,
  input  logic             ovf_in,
  output logic             ovf_seen_out,
  output logic             done_out,
  output logic             busy_out
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = width + 2;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_next_s;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic [1:0]         head_op_s;
  logic [width-1:0]   head_data_s;

  assign full_s        = (count_r == CNT_W'(DEPTH));
  assign empty_s       = (count_r == {CNT_W{1'b0}});
  // Full blocks a push even when a pop happens on the same edge.
  assign push_s        = cmd_valid_in & ~full_s;
  assign cmd_ready_out = ~full_s;
  assign head_op_s     = fifo_mem_r[rd_ptr_r][ENTRY_W-1:width];
  assign head_data_s   = fifo_mem_r[rd_ptr_r][width-1:0];

  // Occupancy for the coming cycle; also feeds the registered busy flag.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_mem_r[i] <= {ENTRY_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd_op_in, cmd_data_in};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Executor FSM
  // rem_r holds the cycles still to go after the current one, so the final
  // cycle of any command is the one with rem_r == 0.
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           next_state_s;
  logic [width-1:0] rem_r;
  logic [width-1:0] rem_next_s;
  logic             final_s;

  logic             en_r;
  logic             set_r;
  logic             up_r;
  logic             done_r;
  logic             busy_r;
  logic             ovf_seen_r;
  logic [width-1:0] value_r;

  logic             en_next_s;
  logic             set_next_s;
  logic             up_next_s;
  logic             done_next_s;
  logic             busy_next_s;
  logic [width-1:0] value_next_s;

  assign final_s = (state_r != ST_IDLE) && (rem_r == {width{1'b0}});

  // Next state, pop decision and next values of the registered controls.
  always_comb begin
    next_state_s = state_r;
    rem_next_s   = rem_r;
    pop_s        = 1'b0;
    en_next_s    = 1'b0;
    set_next_s   = 1'b0;
    up_next_s    = 1'b0;
    done_next_s  = 1'b0;
    value_next_s = value_r;

    if ((state_r == ST_IDLE) || final_s) begin
      if (!empty_s) begin
        // Pop on the same edge that ends the previous command: no bubble.
        pop_s = 1'b1;
        case (head_op_s)
          OP_LOAD: begin
            next_state_s = ST_LOAD;
            rem_next_s   = {width{1'b0}};
            set_next_s   = 1'b1;
            value_next_s = head_data_s;
            done_next_s  = 1'b1;
          end
          OP_UP, OP_DOWN: begin
            if (head_data_s == {width{1'b0}}) begin
              // Zero-length count: a single quiet cycle that still signals done.
              next_state_s = ST_HOLD;
              rem_next_s   = {width{1'b0}};
              done_next_s  = 1'b1;
            end else begin
              next_state_s = ST_RUN;
              rem_next_s   = head_data_s - width'(1);
              en_next_s    = 1'b1;
              up_next_s    = (head_op_s == OP_UP);
              done_next_s  = (head_data_s == width'(1));
            end
          end
          default: begin
            next_state_s = ST_HOLD;
            if (head_data_s == {width{1'b0}}) begin
              rem_next_s = {width{1'b0}};
            end else begin
              rem_next_s = head_data_s - width'(1);
            end
            done_next_s  = (head_data_s <= width'(1));
          end
        endcase
      end else begin
        next_state_s = ST_IDLE;
        rem_next_s   = {width{1'b0}};
      end
    end else begin
      // Mid-command: keep driving the same controls, one fewer cycle to go.
      rem_next_s  = rem_r - width'(1);
      en_next_s   = (state_r == ST_RUN);
      up_next_s   = (state_r == ST_RUN) & up_r;
      done_next_s = (rem_r == width'(1));
    end
  end

  assign busy_next_s = (next_state_s != ST_IDLE) || (count_next_s != {CNT_W{1'b0}});

  // State, remaining count and registered control outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
      rem_r   <= {width{1'b0}};
      en_r    <= 1'b0;
      set_r   <= 1'b0;
      up_r    <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      value_r <= {width{1'b0}};
    end else begin
      state_r <= next_state_s;
      rem_r   <= rem_next_s;
      en_r    <= en_next_s;
      set_r   <= set_next_s;
      up_r    <= up_next_s;
      done_r  <= done_next_s;
      busy_r  <= busy_next_s;
      value_r <= value_next_s;
    end
  end

  // Sticky overflow: only counting cycles can set it, only reset clears it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ovf_seen_r <= 1'b0;
    end else if ((state_r == ST_RUN) && ovf_in) begin
      ovf_seen_r <= 1'b1;
    end else begin
      ovf_seen_r <= ovf_seen_r;
    end
  end

  assign en_ctrl_out       = en_r;
  assign set_ctrl_out      = set_r;
  assign up_ctrl_out       = up_r;
  assign done_out          = done_r;
  assign busy_out          = busy_r;
  assign ovf_seen_out      = ovf_seen_r;
  assign counter_value_out = value_r;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for counter_cmd_sequencer. A command-level reference model (queue
// of pending commands plus the command currently executing and its cycles
// left) predicts every output each cycle; directed scenarios add explicit
// checks of the documented corner cases, then a randomized run follows.
// -----------------------------------------------------------------------------
module tb_counter_cmd_sequencer;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         cmd_valid_in = 1'b0;
  logic         cmd_ready_out;
  logic [1:0]   cmd_op_in = 2'b00;
  logic [W-1:0] cmd_data_in = 8'h00;
  logic         en_ctrl_out;
  logic         set_ctrl_out;
  logic         up_ctrl_out;
  logic [W-1:0] counter_value_out;
  logic         ovf_in = 1'b0;
  logic         ovf_seen_out;
  logic         done_out;
  logic         busy_out;

  counter_cmd_sequencer #(.width(W), .DEPTH(D)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .cmd_valid_in      (cmd_valid_in),
    .cmd_ready_out     (cmd_ready_out),
    .cmd_op_in         (cmd_op_in),
    .cmd_data_in       (cmd_data_in),
    .en_ctrl_out       (en_ctrl_out),
    .set_ctrl_out      (set_ctrl_out),
    .up_ctrl_out       (up_ctrl_out),
    .counter_value_out (counter_value_out),
    .ovf_in            (ovf_in),
    .ovf_seen_out      (ovf_seen_out),
    .done_out          (done_out),
    .busy_out          (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed output bundle: {ready, en, set, up, done, busy, ovf_seen, value}
  logic [14:0] obs;
  assign obs = {cmd_ready_out, en_ctrl_out, set_ctrl_out, up_ctrl_out,
                done_out, busy_out, ovf_seen_out, counter_value_out};

  // ---------------- reference model ----------------
  logic [W+1:0] m_q[$];
  int           m_left;
  bit           m_active, m_en, m_set, m_up, m_done, m_busy, m_ovf, m_run, m_pushed;
  logic [W-1:0] m_val;

  task automatic model_reset();
    m_q.delete();
    m_left = 0; m_active = 0; m_en = 0; m_set = 0; m_up = 0;
    m_done = 0; m_busy = 0; m_ovf = 0; m_run = 0; m_pushed = 0;
    m_val = 8'h00;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_step();
    bit           push;
    logic [W+1:0] c;
    logic [1:0]   op;
    int           n;
    if (!rst_in) begin
      model_reset();
      return;
    end
    push = cmd_valid_in && (m_q.size() < D);
    if (m_run && ovf_in) m_ovf = 1;
    if (m_left == 0) begin
      if (m_q.size() > 0) begin
        c  = m_q.pop_front();
        op = c[W+1:W];
        n  = int'(c[W-1:0]);
        m_active = 1; m_en = 0; m_set = 0; m_up = 0; m_run = 0;
        if (op == 2'b01) begin
          m_set = 1; m_val = c[W-1:0]; m_left = 0;
        end else if (op == 2'b10 || op == 2'b11) begin
          if (n == 0) m_left = 0;
          else begin
            m_en = 1; m_up = (op == 2'b10); m_run = 1; m_left = n - 1;
          end
        end else begin
          m_left = (n == 0) ? 0 : n - 1;
        end
        m_done = (m_left == 0);
      end else begin
        m_active = 0; m_en = 0; m_set = 0; m_up = 0; m_done = 0; m_run = 0;
      end
    end else begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
    end
    if (push) m_q.push_back({cmd_op_in, cmd_data_in});
    m_pushed = push;
    m_busy = m_active || (m_q.size() > 0);
  endtask

  function automatic logic [14:0] exp_vec();
    bit rdy;
    rdy = (m_q.size() < D);
    return {rdy, m_en, m_set, m_up, m_done, m_busy, m_ovf, m_val};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] data);
    cmd_valid_in = 1'b1; cmd_op_in = op; cmd_data_in = data;
  endtask

  task automatic do_reset();
    rst_in = 1'b0; cmd_valid_in = 1'b0; ovf_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== 15'h4000) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 15'h4000);
    end
    tick();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_load();
    do_reset();
    drive(2'b01, 8'h5A);
    tick();
    cmd_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL load cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i == 0) tick();
      else if (i == 1) begin
        n_checks++;
        if ({set_ctrl_out, done_out, en_ctrl_out, counter_value_out} !== {3'b110, 8'h5A}) begin
          n_fail++; $display("FAIL load_pulse: got set=%b done=%b en=%b val=%h expected 1 1 0 5a",
                             set_ctrl_out, done_out, en_ctrl_out, counter_value_out);
        end
        tick();
      end else begin
        n_checks++;
        if ({set_ctrl_out, done_out, busy_out, counter_value_out} !== {3'b000, 8'h5A}) begin
          n_fail++; $display("FAIL load_after: got set=%b done=%b busy=%b val=%h expected 0 0 0 5a",
                             set_ctrl_out, done_out, busy_out, counter_value_out);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] en_h, up_h, done_h;
    do_reset();
    en_h = 8'h00; up_h = 8'h00; done_h = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(2'b10, 8'd3);
      else if (i == 1) drive(2'b11, 8'd2);
      else cmd_valid_in = 1'b0;
      tick();
      en_h[i] = en_ctrl_out; up_h[i] = up_ctrl_out; done_h[i] = done_out;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if ({en_h, up_h, done_h} !== {8'b0011_1110, 8'b0000_1110, 8'b0010_1000}) begin
      n_fail++; $display("FAIL back_to_back_trace: got en=%b up=%b done=%b expected en=00111110 up=00001110 done=00101000",
                         en_h, up_h, done_h);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0]   ops [5];
    logic [W-1:0] dat [5];
    bit           accepted;
    ops = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    dat = '{8'd20, 8'd1, 8'd2, 8'h33, 8'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], dat[i]);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL fifo_fill cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if (cmd_ready_out !== 1'b0) begin
      n_fail++; $display("FAIL fifo_full_ready: got %b expected 0", cmd_ready_out);
    end
    drive(2'b01, 8'h77);
    accepted = 0;
    for (int i = 0; i < 40 && !accepted; i++) begin
      tick();
      accepted = m_pushed;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL fifo_wait cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    cmd_valid_in = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++; $display("FAIL fifo_fifth_push: got not accepted expected accepted");
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL fifo_drain cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    n_checks++;
    if ({busy_out, counter_value_out} !== {1'b0, 8'h77}) begin
      n_fail++; $display("FAIL fifo_final: got busy=%b val=%h expected 0 77", busy_out, counter_value_out);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(2'b10, 8'd0);
      else if (i == 1) drive(2'b00, 8'd0);
      else cmd_valid_in = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL zero_count cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i == 1 || i == 2) begin
        n_checks++;
        if ({en_ctrl_out, set_ctrl_out, up_ctrl_out, done_out} !== 4'b0001) begin
          n_fail++; $display("FAIL zero_count_pulse cyc %0d: got %b expected 0001", i,
                             {en_ctrl_out, set_ctrl_out, up_ctrl_out, done_out});
        end
      end
    end
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_fail++; $display("FAIL zero_count_busy: got %b expected 0", busy_out);
    end
  endtask

  task automatic test_ovf();
    do_reset();
    drive(2'b00, 8'd5);
    ovf_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      cmd_valid_in = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_hold cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    ovf_in = 1'b0;
    n_checks++;
    if (ovf_seen_out !== 1'b0) begin
      n_fail++; $display("FAIL ovf_hold_sticky: got %b expected 0", ovf_seen_out);
    end
    drive(2'b10, 8'd10);
    for (int i = 0; i < 16; i++) begin
      tick();
      cmd_valid_in = 1'b0;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL ovf_run cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i == 4) ovf_in = 1'b1;
      if (i == 5) begin
        ovf_in = 1'b0;
        n_checks++;
        if (ovf_seen_out !== 1'b1) begin
          n_fail++; $display("FAIL ovf_set: got %b expected 1", ovf_seen_out);
        end
      end
    end
    n_checks++;
    if ({ovf_seen_out, busy_out} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_stays: got ovf=%b busy=%b expected 1 0", ovf_seen_out, busy_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive(2'b11, 8'd8);
      else if (i == 1) drive(2'b10, 8'd2);
      else if (i == 2) drive(2'b00, 8'd3);
      else cmd_valid_in = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid_pre cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 15'h4000) begin
      n_fail++; $display("FAIL reset_mid_async: got %h expected %h", obs, 15'h4000);
    end
    tick(); tick();
    rst_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL reset_mid_post cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        if (op == 2'b01) drive(op, 8'($urandom_range(0, 255)));
        else drive(op, 8'($urandom_range(0, 4)));
      end else begin
        cmd_valid_in = 1'b0;
      end
      ovf_in = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    cmd_valid_in = 1'b0;
    ovf_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random_drain cyc %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_back_to_back();
    test_fifo_full();
    test_zero_count();
    test_ovf();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
